// File: rtl/tcdm2axi_bridge.sv
// TCDM requester to AXI4 master bridge: each TCDM access becomes one single-beat
// AXI transaction, strictly one outstanding transfer at a time.
module tcdm2axi_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        tcdm_slave_req_i,
    input  logic [31:0]                 tcdm_slave_add_i,
    input  logic                        tcdm_slave_we_n_i,
    input  logic [3:0]                  tcdm_slave_be_i,
    input  logic [31:0]                 tcdm_slave_data_i,
    output logic                        tcdm_slave_gnt_o,
    output logic                        tcdm_slave_r_valid_o,
    output logic [31:0]                 tcdm_slave_r_data_o,
    output logic                        tcdm_slave_r_opc_o,

    output logic                        axi_master_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_master_aw_addr_o,
    output logic [2:0]                  axi_master_aw_prot_o,
    output logic [3:0]                  axi_master_aw_region_o,
    output logic [7:0]                  axi_master_aw_len_o,
    output logic [2:0]                  axi_master_aw_size_o,
    output logic [1:0]                  axi_master_aw_burst_o,
    output logic                        axi_master_aw_lock_o,
    output logic [3:0]                  axi_master_aw_cache_o,
    output logic [3:0]                  axi_master_aw_qos_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_master_aw_id_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_master_aw_user_o,
    input  logic                        axi_master_aw_ready_i,

    output logic                        axi_master_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_master_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_master_w_strb_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_master_w_user_o,
    output logic                        axi_master_w_last_o,
    input  logic                        axi_master_w_ready_i,

    input  logic                        axi_master_b_valid_i,
    input  logic [1:0]                  axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_master_b_id_i,
    output logic                        axi_master_b_ready_o,

    output logic                        axi_master_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_master_ar_addr_o,
    output logic [2:0]                  axi_master_ar_prot_o,
    output logic [3:0]                  axi_master_ar_region_o,
    output logic [7:0]                  axi_master_ar_len_o,
    output logic [2:0]                  axi_master_ar_size_o,
    output logic [1:0]                  axi_master_ar_burst_o,
    output logic                        axi_master_ar_lock_o,
    output logic [3:0]                  axi_master_ar_cache_o,
    output logic [3:0]                  axi_master_ar_qos_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_master_ar_id_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_master_ar_user_o,
    input  logic                        axi_master_ar_ready_i,

    input  logic                        axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_master_r_data_i,
    input  logic [1:0]                  axi_master_r_resp_i,
    input  logic                        axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_master_r_id_i,
    output logic                        axi_master_r_ready_o,

    output logic                        busy_o
);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RSP} state_t;

    localparam int unsigned LANES  = AXI_DATA_WIDTH / 32;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    state_t                     state, state_next;
    logic [29:0]                addr_q;
    logic [3:0]                 be_q;
    logic [31:0]                wdata_q;
    logic [31:0]                rdata_q;
    logic                       opc_q;
    logic                       aw_done, w_done;
    logic [LANE_W-1:0]          lane;
    logic [LANES-1:0][31:0]     r_lanes;
    logic                       aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                       unused;

    assign unused = ^{tcdm_slave_add_i[1:0], axi_master_b_id_i, axi_master_r_last_i,
                      axi_master_r_id_i, axi_master_b_resp_i[0], axi_master_r_resp_i[0]};

    // Reset also masks the grant so a held request is never accepted while in reset
    assign tcdm_slave_gnt_o = tcdm_slave_req_i & (state == IDLE) & rst_ni;

    assign lane    = LANE_W'(32'(addr_q) % LANES);
    assign r_lanes = axi_master_r_data_i;

    assign aw_hs = axi_master_aw_valid_o & axi_master_aw_ready_i;
    assign w_hs  = axi_master_w_valid_o  & axi_master_w_ready_i;
    assign b_hs  = axi_master_b_valid_i  & axi_master_b_ready_o;
    assign ar_hs = axi_master_ar_valid_o & axi_master_ar_ready_i;
    assign r_hs  = axi_master_r_valid_i  & axi_master_r_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (tcdm_slave_gnt_o) state_next = tcdm_slave_we_n_i ? RD_A : WR;
            WR:   if ((aw_done | aw_hs) & (w_done | w_hs)) state_next = WR_B;
            WR_B: if (b_hs) state_next = RSP;
            RD_A: if (ar_hs) state_next = RD_D;
            RD_D: if (r_hs) state_next = RSP;
            RSP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        axi_master_aw_valid_o = 1'b0;
        axi_master_w_valid_o  = 1'b0;
        axi_master_b_ready_o  = 1'b0;
        axi_master_ar_valid_o = 1'b0;
        axi_master_r_ready_o  = 1'b0;
        tcdm_slave_r_valid_o  = 1'b0;
        busy_o                = (state != IDLE);
        case (state)
            WR: begin
                axi_master_aw_valid_o = ~aw_done;
                axi_master_w_valid_o  = ~w_done;
            end
            WR_B:    axi_master_b_ready_o  = 1'b1;
            RD_A:    axi_master_ar_valid_o = 1'b1;
            RD_D:    axi_master_r_ready_o  = 1'b1;
            RSP:     tcdm_slave_r_valid_o  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            opc_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (tcdm_slave_gnt_o) begin
                addr_q  <= tcdm_slave_add_i[31:2];
                be_q    <= tcdm_slave_be_i;
                wdata_q <= tcdm_slave_data_i;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (b_hs) begin
                rdata_q <= '0;
                opc_q   <= axi_master_b_resp_i[1];
            end
            if (r_hs) begin
                rdata_q <= r_lanes[lane];
                opc_q   <= axi_master_r_resp_i[1];
            end
        end
    end

    assign tcdm_slave_r_data_o = rdata_q;
    assign tcdm_slave_r_opc_o  = opc_q;

    assign axi_master_aw_addr_o   = AXI_ADDR_WIDTH'({addr_q, 2'b00});
    assign axi_master_aw_len_o    = 8'd0;
    assign axi_master_aw_size_o   = 3'd2;
    assign axi_master_aw_burst_o  = 2'b01;
    assign axi_master_aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_master_aw_prot_o   = '0;
    assign axi_master_aw_region_o = '0;
    assign axi_master_aw_lock_o   = 1'b0;
    assign axi_master_aw_cache_o  = '0;
    assign axi_master_aw_qos_o    = '0;
    assign axi_master_aw_user_o   = '0;

    assign axi_master_w_data_o = {LANES{wdata_q}};
    assign axi_master_w_strb_o = STRB_W'(be_q) << {lane, 2'b00};
    assign axi_master_w_last_o = 1'b1;
    assign axi_master_w_user_o = '0;

    assign axi_master_ar_addr_o   = AXI_ADDR_WIDTH'({addr_q, 2'b00});
    assign axi_master_ar_len_o    = 8'd0;
    assign axi_master_ar_size_o   = 3'd2;
    assign axi_master_ar_burst_o  = 2'b01;
    assign axi_master_ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_master_ar_prot_o   = '0;
    assign axi_master_ar_region_o = '0;
    assign axi_master_ar_lock_o   = 1'b0;
    assign axi_master_ar_cache_o  = '0;
    assign axi_master_ar_qos_o    = '0;
    assign axi_master_ar_user_o   = '0;

endmodule

// File: tb/tb_tcdm2axi_bridge.sv
// Bench for tcdm2axi_bridge: scripted AXI slave per transaction, TCDM responses
// checked against a scoreboard of expected {r_data, r_opc}.
module tb_tcdm2axi_bridge;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int UW = 6;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req, we_n, gnt, r_valid, r_opc;
    logic [31:0]   add, wdata, r_data;
    logic [3:0]    be;
    logic          aw_valid, aw_ready, aw_lock, w_valid, w_ready, w_last;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [2:0]    aw_prot, aw_size, ar_prot, ar_size;
    logic [3:0]    aw_region, aw_cache, aw_qos, ar_region, ar_cache, ar_qos;
    logic [7:0]    aw_len, ar_len;
    logic [1:0]    aw_burst, ar_burst, b_resp, r_resp;
    logic [IW-1:0] aw_id, ar_id, b_id, r_id;
    logic [UW-1:0] aw_user, ar_user, w_user;
    logic [DW-1:0] w_data, axi_r_data;
    logic [DW/8-1:0] w_strb;
    logic          b_valid, b_ready, ar_valid, ar_ready, ar_lock;
    logic          axi_r_valid, axi_r_last, r_ready, busy;

    tcdm2axi_bridge #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW),
        .AXI_ID_WIDTH(IW), .AXI_ID(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .tcdm_slave_req_i(req), .tcdm_slave_add_i(add), .tcdm_slave_we_n_i(we_n),
        .tcdm_slave_be_i(be), .tcdm_slave_data_i(wdata), .tcdm_slave_gnt_o(gnt),
        .tcdm_slave_r_valid_o(r_valid), .tcdm_slave_r_data_o(r_data), .tcdm_slave_r_opc_o(r_opc),
        .axi_master_aw_valid_o(aw_valid), .axi_master_aw_addr_o(aw_addr),
        .axi_master_aw_prot_o(aw_prot), .axi_master_aw_region_o(aw_region),
        .axi_master_aw_len_o(aw_len), .axi_master_aw_size_o(aw_size),
        .axi_master_aw_burst_o(aw_burst), .axi_master_aw_lock_o(aw_lock),
        .axi_master_aw_cache_o(aw_cache), .axi_master_aw_qos_o(aw_qos),
        .axi_master_aw_id_o(aw_id), .axi_master_aw_user_o(aw_user),
        .axi_master_aw_ready_i(aw_ready),
        .axi_master_w_valid_o(w_valid), .axi_master_w_data_o(w_data),
        .axi_master_w_strb_o(w_strb), .axi_master_w_user_o(w_user),
        .axi_master_w_last_o(w_last), .axi_master_w_ready_i(w_ready),
        .axi_master_b_valid_i(b_valid), .axi_master_b_resp_i(b_resp),
        .axi_master_b_id_i(b_id), .axi_master_b_ready_o(b_ready),
        .axi_master_ar_valid_o(ar_valid), .axi_master_ar_addr_o(ar_addr),
        .axi_master_ar_prot_o(ar_prot), .axi_master_ar_region_o(ar_region),
        .axi_master_ar_len_o(ar_len), .axi_master_ar_size_o(ar_size),
        .axi_master_ar_burst_o(ar_burst), .axi_master_ar_lock_o(ar_lock),
        .axi_master_ar_cache_o(ar_cache), .axi_master_ar_qos_o(ar_qos),
        .axi_master_ar_id_o(ar_id), .axi_master_ar_user_o(ar_user),
        .axi_master_ar_ready_i(ar_ready),
        .axi_master_r_valid_i(axi_r_valid), .axi_master_r_data_i(axi_r_data),
        .axi_master_r_resp_i(r_resp), .axi_master_r_last_i(axi_r_last),
        .axi_master_r_id_i(r_id), .axi_master_r_ready_o(r_ready),
        .busy_o(busy)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [32:0] sb[$];
    logic [32:0] sb_exp;

    // Response monitor: every r_valid_o pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && r_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: r_valid with empty scoreboard, data=%h", r_data);
            end else begin
                sb_exp = sb.pop_front();
                if ({r_data, r_opc} !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_rsp: got data=%h opc=%b, want data=%h opc=%b",
                             r_data, r_opc, sb_exp[32:1], sb_exp[0]);
                end
            end
        end
    end

    // Drives one TCDM access and plays the AXI slave; starts just after a negedge in IDLE
    task automatic axi_txn(input logic t_we_n, input logic [31:0] t_add, input logic [3:0] t_be,
                           input logic [31:0] t_wd, input int unsigned a_wait,
                           input int unsigned w_wait, input logic [1:0] resp,
                           input logic [63:0] rd, input bit hold_req);
        logic [7:0]  exp_strb;
        logic [31:0] exp_rd, exp_addr;
        logic        aw_d, w_d, hs_aw, hs_w, hs;
        exp_strb = 8'(t_be) << (4 * int'(t_add[2]));
        exp_rd   = !t_we_n ? 32'h0 : (t_add[2] ? rd[63:32] : rd[31:0]);
        exp_addr = {t_add[31:2], 2'b00};
        req = 1'b1; we_n = t_we_n; add = t_add; be = t_be; wdata = t_wd;
        #1;
        n_cmp++;
        if (gnt !== 1'b1) begin
            n_err++; $display("FAIL grant: gnt=%b want 1", gnt);
        end
        sb.push_back({exp_rd, resp[1]});
        @(negedge clk);
        if (!hold_req) req = 1'b0;
        if (!t_we_n) begin
            aw_d = 1'b0; w_d = 1'b0;
            for (int c = 0; c < 20 && !(aw_d && w_d); c++) begin
                aw_ready = (c >= int'(a_wait)); w_ready = (c >= int'(w_wait));
                #1;
                n_cmp++;
                if (aw_valid !== !aw_d || w_valid !== !w_d || b_ready !== 1'b0 ||
                    busy !== 1'b1 || gnt !== 1'b0) begin
                    n_err++;
                    $display("FAIL wr_chan c=%0d: aw_valid=%b w_valid=%b b_ready=%b busy=%b gnt=%b, want %b %b 0 1 0",
                             c, aw_valid, w_valid, b_ready, busy, gnt, !aw_d, !w_d);
                end
                if (!aw_d && (aw_addr !== exp_addr || aw_len !== 8'd0 || aw_size !== 3'd2 ||
                              aw_burst !== 2'b01 || aw_id !== '0)) begin
                    n_err++;
                    $display("FAIL aw_fields: addr=%h len=%h size=%h burst=%b id=%h, want %h 0 2 01 0",
                             aw_addr, aw_len, aw_size, aw_burst, aw_id, exp_addr);
                end
                if (!w_d && (w_data !== {t_wd, t_wd} || w_strb !== exp_strb || w_last !== 1'b1)) begin
                    n_err++;
                    $display("FAIL w_fields: data=%h strb=%h last=%b, want %h %h 1",
                             w_data, w_strb, w_last, {t_wd, t_wd}, exp_strb);
                end
                hs_aw = aw_valid & aw_ready;
                hs_w  = w_valid & w_ready;
                @(negedge clk);
                aw_d = aw_d | hs_aw;
                w_d  = w_d | hs_w;
            end
            n_cmp++;
            if (!(aw_d && w_d)) begin
                n_err++; $display("FAIL wr_timeout: aw_done=%b w_done=%b want 1 1", aw_d, w_d);
            end
            aw_ready = 1'b0; w_ready = 1'b0;
            #1;
            n_cmp++;
            if (b_ready !== 1'b1 || aw_valid !== 1'b0 || w_valid !== 1'b0) begin
                n_err++;
                $display("FAIL b_phase: b_ready=%b aw_valid=%b w_valid=%b, want 1 0 0",
                         b_ready, aw_valid, w_valid);
            end
            b_valid = 1'b1; b_resp = resp;
            @(negedge clk);
            b_valid = 1'b0; b_resp = 2'b00;
        end else begin
            hs = 1'b0;
            for (int c = 0; c < 20 && !hs; c++) begin
                ar_ready = (c >= int'(a_wait));
                #1;
                n_cmp++;
                if (ar_valid !== 1'b1 || ar_addr !== exp_addr || ar_len !== 8'd0 ||
                    ar_size !== 3'd2 || ar_burst !== 2'b01 || ar_id !== '0 ||
                    r_ready !== 1'b0 || busy !== 1'b1 || gnt !== 1'b0) begin
                    n_err++;
                    $display("FAIL ar_chan c=%0d: valid=%b addr=%h len=%h size=%h burst=%b r_ready=%b busy=%b gnt=%b, want 1 %h 0 2 01 0 1 0",
                             c, ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready, busy, gnt, exp_addr);
                end
                hs = ar_ready;
                @(negedge clk);
            end
            ar_ready = 1'b0;
            #1;
            n_cmp++;
            if (ar_valid !== 1'b0 || r_ready !== 1'b1) begin
                n_err++;
                $display("FAIL r_phase: ar_valid=%b r_ready=%b, want 0 1", ar_valid, r_ready);
            end
            axi_r_valid = 1'b1; axi_r_data = rd; r_resp = resp; axi_r_last = 1'b1;
            @(negedge clk);
            axi_r_valid = 1'b0; axi_r_data = '0; r_resp = 2'b00; axi_r_last = 1'b0;
        end
        #1;
        n_cmp++;
        if (r_valid !== 1'b1 || busy !== 1'b1 || gnt !== 1'b0 || b_ready !== 1'b0 || r_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_cycle: r_valid=%b busy=%b gnt=%b b_ready=%b r_ready=%b, want 1 1 0 0 0",
                     r_valid, busy, gnt, b_ready, r_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (r_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_one_cycle: r_valid=%b busy=%b, want 0 0", r_valid, busy);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (gnt !== 1'b0 || busy !== 1'b0 || aw_valid !== 1'b0 || w_valid !== 1'b0 ||
            ar_valid !== 1'b0 || b_ready !== 1'b0 || r_ready !== 1'b0 || r_valid !== 1'b0 ||
            r_data !== 32'h0 || aw_addr !== '0 || ar_addr !== '0) begin
            n_err++;
            $display("FAIL reset_state: gnt=%b busy=%b awv=%b wv=%b arv=%b br=%b rr=%b rv=%b rdata=%h awaddr=%h, want all 0",
                     gnt, busy, aw_valid, w_valid, ar_valid, b_ready, r_ready, r_valid, r_data, aw_addr);
        end
        n_cmp++;
        if ({aw_prot, aw_region, aw_lock, aw_cache, aw_qos, aw_user, w_user,
             ar_prot, ar_region, ar_lock, ar_cache, ar_qos, ar_user} !== '0) begin
            n_err++;
            $display("FAIL const_zero: side-band outputs not all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle: busy=%b gnt=%b want 0 0", busy, gnt);
        end
    endtask

    task automatic test_write();
        axi_txn(1'b0, 32'h1000_0004, 4'hC, 32'hDEAD_BEEF, 0, 0, 2'b00, 64'h0, 1'b0);
        axi_txn(1'b0, 32'h2000_0008, 4'h3, 32'h0123_4567, 0, 2, 2'b00, 64'h0, 1'b0);
    endtask

    task automatic test_read();
        axi_txn(1'b1, 32'h1000_0000, 4'h0, 32'h0, 0, 0, 2'b00, 64'h1122_3344_5566_7788, 1'b0);
        axi_txn(1'b1, 32'h1000_0004, 4'h0, 32'h0, 2, 0, 2'b00, 64'h1122_3344_5566_7788, 1'b0);
    endtask

    task automatic test_aw_stall();
        axi_txn(1'b0, 32'h3000_0000, 4'hF, 32'hCAFE_F00D, 3, 0, 2'b00, 64'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        axi_txn(1'b1, 32'h4000_0000, 4'h0, 32'h0, 0, 0, 2'b00, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
        axi_txn(1'b1, 32'h4000_0004, 4'h0, 32'h0, 0, 0, 2'b00, 64'h9999_8888_7777_6666, 1'b0);
    endtask

    task automatic test_errors();
        axi_txn(1'b1, 32'h5000_0004, 4'h0, 32'h0, 0, 0, 2'b10, 64'hFEED_FACE_0BAD_F00D, 1'b0);
        axi_txn(1'b0, 32'h5000_0000, 4'h1, 32'h5555_AAAA, 0, 0, 2'b11, 64'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req = 1'b1; we_n = 1'b1; add = 32'h6000_0000;
        #1;
        n_cmp++;
        if (gnt !== 1'b1) begin
            n_err++; $display("FAIL mid_grant: gnt=%b want 1", gnt);
        end
        @(negedge clk);
        req = 1'b0; ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        #1;
        n_cmp++;
        if (r_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_rd_d: r_ready=%b want 1", r_ready);
        end
        req = 1'b1; rst_n = 1'b0;
        #1;
        n_cmp++;
        if (r_ready !== 1'b0 || busy !== 1'b0 || gnt !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: r_ready=%b busy=%b gnt=%b, want 0 0 0", r_ready, busy, gnt);
        end
        @(negedge clk);
        req = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        axi_txn(1'b1, 32'h6000_0004, 4'h0, 32'h0, 0, 0, 2'b00, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b0; add = '0; we_n = 1'b1; be = '0; wdata = '0;
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
        b_valid = 1'b0; b_resp = 2'b00; b_id = '0;
        axi_r_valid = 1'b0; axi_r_data = '0; r_resp = 2'b00; axi_r_last = 1'b0; r_id = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_aw_stall();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: %0d expected responses never seen, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
